// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: Wishbone classic single-transfer initiator.
// Commands arrive on a valid/ready stream into a small FIFO. Each command
// becomes one Wishbone cycle, and each cycle returns one response on a
// valid/ready stream, in command order.
// Optional feature macro: WB_INIT_TIMEOUT_EN enables the ack timeout and
// abort path. Without it, BUS waits for ack indefinitely and rsp_err is 0.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/ready, cmd_we/adr/dat/sel   command stream (input)
//   rsp_valid/ready, rsp_dat/err    response stream (output)
//   wbm_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o, wbm_dat_i/ack_i   Wishbone master
//   busy                            FIFO non-empty or FSM not idle
module wb_cmd_initiator #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TSIZE      = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Elaboration-time parameter sanity checks
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (64'(TIMEOUT) >= (64'd1 << TSIZE)) begin : g_chk_timeout
    $error("TIMEOUT must be below 2**TSIZE");
  end

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // Command FIFO storage and pointers
  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_cmd_ready;

  state_t      r_state;
  logic        r_cyc, r_we, r_rsp_valid, r_busy;
  logic [31:0] r_adr, r_dat, r_rsp_dat;
  logic [3:0]  r_sel;

  cmd_t        w_cmd_in, w_head;
  logic        w_push, w_pop, w_empty;
  logic [CNT_W-1:0] w_count_nxt;
  state_t      w_state_nxt;
  logic        w_cyc_nxt, w_we_nxt, w_rsp_valid_nxt;
  logic [31:0] w_adr_nxt, w_dat_nxt, w_rsp_dat_nxt;
  logic [3:0]  w_sel_nxt;

`ifdef WB_INIT_TIMEOUT_EN
  logic [TSIZE-1:0] r_tmo, w_tmo_nxt, w_tmo_inc;
  logic             r_rsp_err, w_rsp_err_nxt;
  assign w_tmo_inc = r_tmo + TSIZE'(1);
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

  assign w_cmd_in = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
  assign w_head   = r_mem[r_rd_ptr];
  assign w_empty  = (r_count == '0);
  // Admission depends only on the registered full flag
  assign w_push   = cmd_valid && r_cmd_ready;

  // FIFO data array (no reset needed on payload)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cmd_in;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_sel_nxt       = r_sel;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_pop           = 1'b0;
`ifdef WB_INIT_TIMEOUT_EN
    w_tmo_nxt       = r_tmo;
    w_rsp_err_nxt   = r_rsp_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_we_nxt    = w_head.we;
          w_adr_nxt   = w_head.adr;
          w_dat_nxt   = w_head.dat;
          w_sel_nxt   = w_head.sel;
          w_cyc_nxt   = 1'b1;
          w_state_nxt = S_BUS;
`ifdef WB_INIT_TIMEOUT_EN
          w_tmo_nxt   = '0;
`endif
        end
      end
      S_BUS: begin
        // Ack takes priority over a coincident timeout
        if (wbm_ack_i) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_dat_nxt   = r_we ? 32'h0 : wbm_dat_i;
          w_state_nxt     = S_RESP;
`ifdef WB_INIT_TIMEOUT_EN
          w_rsp_err_nxt   = 1'b0;
        end else begin
          w_tmo_nxt = w_tmo_inc;
          if (w_tmo_inc == TSIZE'(TIMEOUT)) begin
            w_cyc_nxt       = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_dat_nxt   = 32'h0;
            w_rsp_err_nxt   = 1'b1;
            w_state_nxt     = S_RESP;
          end
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // State, FIFO pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
`ifdef WB_INIT_TIMEOUT_EN
      r_tmo       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
      r_busy      <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_sel       <= w_sel_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
`ifdef WB_INIT_TIMEOUT_EN
      r_tmo       <= w_tmo_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
`endif
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = r_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed self-checking bench for wb_cmd_initiator (FIFO_DEPTH=4, TIMEOUT=10).
module tb_wb_cmd_initiator;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int xfers   = 0;

  // Slave model: 0 = never ack, 1 = ack while stb, 2 = ack while stb plus one lingering cycle
  logic [1:0] ack_mode;
  logic       r_linger;
  localparam logic [31:0] RD_KEY = 32'h3000_0023;

  assign wbm_dat_i = wbm_adr_o ^ RD_KEY;
  assign wbm_ack_i = ((ack_mode != 2'd0) && wbm_cyc_o && wbm_stb_o) || r_linger;

  always @(posedge clk) begin
    r_linger <= (ack_mode == 2'd2) && wbm_cyc_o && wbm_stb_o;
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) xfers <= xfers + 1;
  end

  wb_cmd_initiator #(.FIFO_DEPTH(4), .TSIZE(8), .TIMEOUT(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    check("push_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int x0;
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; ack_mode = 2'd1;
    tick(); tick();
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single write, minimum latency
    push(1'b1, 32'h3000_0004, 32'h0000_002A);
    check("wr_no_bypass", 32'(wbm_cyc_o), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    tick();
    check("wr_cyc", 32'(wbm_cyc_o), 32'd1);
    check("wr_stb", 32'(wbm_stb_o), 32'd1);
    check("wr_we", 32'(wbm_we_o), 32'd1);
    check("wr_adr", wbm_adr_o, 32'h3000_0004);
    check("wr_dat", wbm_dat_o, 32'h0000_002A);
    check("wr_sel", 32'(wbm_sel_o), 32'hF);
    check("wr_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_dat", rsp_dat, 32'h0);
    check("wr_rsp_err", 32'(rsp_err), 32'd0);
    check("wr_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    check("wr_xfers", 32'(xfers), 32'd1);
    consume();
    check("wr_rsp_taken", 32'(rsp_valid), 32'd0);
    check("wr_idle_busy", 32'(busy), 32'd0);

    // Read-back
    push(1'b0, 32'h3000_0008, 32'h0);
    tick();
    check("rd_we", 32'(wbm_we_o), 32'd0);
    check("rd_sel", 32'(wbm_sel_o), 32'hF);
    check("rd_adr", wbm_adr_o, 32'h3000_0008);
    tick();
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_dat", rsp_dat, 32'h0000_002B);
    check("rd_xfers", 32'(xfers), 32'd2);
    consume();

    // Response backpressure with a slave whose ack lingers after stb falls
    ack_mode = 2'd2;
    push(1'b0, 32'h3000_0010, 32'h0);
    wait_rsp("bp_rsp1");
    push(1'b0, 32'h3000_0014, 32'h0);
    x0 = xfers;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_dat_hold", rsp_dat, 32'h0000_0033);
      check("bp_stb_idle", 32'(wbm_stb_o), 32'd0);
      tick();
    end
    check("bp_no_new_xfer", 32'(xfers), 32'(x0));
    consume();
    check("bp_taken", 32'(rsp_valid), 32'd0);
    wait_rsp("bp_rsp2");
    check("bp_rsp2_dat", rsp_dat, 32'h0000_0037);
    check("bp_rsp2_xfers", 32'(xfers), 32'(x0 + 1));
    consume();
    ack_mode = 2'd1;

    // FIFO full and ordering
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("full_ready_before5", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0100 + 32'(4 * i); cmd_sel = 4'hF;
      tick();
    end
    cmd_adr = 32'h3000_0114;
    check("full_ready_low", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_stall", 32'(cmd_ready), 32'd0);
    end
    check("full_rsp0_valid", 32'(rsp_valid), 32'd1);
    check("full_rsp0_dat", rsp_dat, 32'h3000_0100 ^ RD_KEY);
    consume();
    n = 0;
    while (!cmd_ready && n < 10) begin
      tick();
      n++;
    end
    check("full_ready_again", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    for (int j = 1; j < 6; j++) begin
      wait_rsp("full_rsp_valid");
      check("full_rsp_order", rsp_dat, (32'h3000_0100 + 32'(4 * j)) ^ RD_KEY);
      consume();
    end
    check("full_drained_busy", 32'(busy), 32'd0);

`ifdef WB_INIT_TIMEOUT_EN
    // Timeout: slave never acks
    ack_mode = 2'd0;
    push(1'b0, 32'h3000_0040, 32'h0);
    tick();
    n = 0;
    while (wbm_cyc_o && n < 50) begin
      n++;
      tick();
    end
    check("tmo_cyc_cycles", 32'(n), 32'd10);
    check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tmo_rsp_err", 32'(rsp_err), 32'd1);
    check("tmo_rsp_dat", rsp_dat, 32'h0);
    consume();
    ack_mode = 2'd1;
    push(1'b0, 32'h3000_0044, 32'h0);
    wait_rsp("tmo_next_valid");
    check("tmo_next_err", 32'(rsp_err), 32'd0);
    check("tmo_next_dat", rsp_dat, 32'h3000_0044 ^ RD_KEY);
    consume();
`else
    // Without the timeout, BUS waits for ack indefinitely
    ack_mode = 2'd0;
    push(1'b0, 32'h3000_0040, 32'h0);
    tick();
    for (int i = 0; i < 30; i++) tick();
    check("wait_cyc_held", 32'(wbm_cyc_o), 32'd1);
    check("wait_no_rsp", 32'(rsp_valid), 32'd0);
    ack_mode = 2'd1;
    tick();
    check("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wait_rsp_err", 32'(rsp_err), 32'd0);
    check("wait_rsp_dat", rsp_dat, 32'h3000_0040 ^ RD_KEY);
    consume();
`endif

    // Reset during BUS with a pending command
    ack_mode = 2'd0;
    push(1'b1, 32'h3000_0050, 32'h1234_5678);
    push(1'b1, 32'h3000_0054, 32'h0);
    check("mid_stb", 32'(wbm_stb_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("mid_rst_stb", 32'(wbm_stb_o), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
